// File: rtl/axis_switch_pkg.sv
// Shared types and helpers for the AXI Stream switch egress path.
// Holds the port FSM state type, default beat layout and bus slicing helper.
package axis_switch_pkg;

    localparam int DEF_N_IN       = 8;
    localparam int DEF_DATA_WIDTH = 64;
    localparam int DEF_USER_WIDTH = 1;

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } sw_state_t;

    typedef struct packed {
        logic [DEF_DATA_WIDTH-1:0]   tdata;
        logic [DEF_DATA_WIDTH/8-1:0] tkeep;
        logic                        tlast;
        logic [DEF_USER_WIDTH-1:0]   tuser;
    } beat_t;

    // LSB of source idx inside a bus flattened at width bits per source.
    function automatic int unsigned src_lsb(
        input int unsigned idx,
        input int unsigned width
    );
        return idx * width;
    endfunction

endpackage

// File: rtl/axis_out_reg.sv
// Single-entry registered AXI Stream output slice.
// Ports: i_* beat in, o_ready = slot free, m_axis_* registered egress.
module axis_out_reg #(
    parameter int DATA_WIDTH = 64,
    parameter int USER_WIDTH = 1
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    i_valid,
    input  logic [DATA_WIDTH-1:0]   i_data,
    input  logic [DATA_WIDTH/8-1:0] i_keep,
    input  logic                    i_last,
    input  logic [USER_WIDTH-1:0]   i_user,
    output logic                    o_ready,
    output logic                    m_axis_tvalid,
    output logic [DATA_WIDTH-1:0]   m_axis_tdata,
    output logic [DATA_WIDTH/8-1:0] m_axis_tkeep,
    output logic                    m_axis_tlast,
    output logic [USER_WIDTH-1:0]   m_axis_tuser,
    input  logic                    m_axis_tready
);

    logic                    r_valid;
    logic [DATA_WIDTH-1:0]   r_data;
    logic [DATA_WIDTH/8-1:0] r_keep;
    logic                    r_last;
    logic [USER_WIDTH-1:0]   r_user;
    logic                    w_free;
    logic                    w_load;

    // Slot can take a beat when empty or being drained this cycle.
    assign w_free = !r_valid || m_axis_tready;
    assign w_load = i_valid && w_free;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_keep  <= '0;
            r_last  <= 1'b0;
            r_user  <= '0;
        end else if (w_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
            r_keep  <= i_keep;
            r_last  <= i_last;
            r_user  <= i_user;
        end else if (m_axis_tready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_ready       = w_free;
    assign m_axis_tvalid = r_valid;
    assign m_axis_tdata  = r_data;
    assign m_axis_tkeep  = r_keep;
    assign m_axis_tlast  = r_last;
    assign m_axis_tuser  = r_user;

endmodule

// File: rtl/axis_switch_out_port.sv
// Egress port stage: arbitrates once per packet, locks the granted source
// until tlast, and muxes it onto a registered AXI Stream master.
// Ports: s_axis_* flattened sources, m_axis_* egress, arb_* external arbiter.
module axis_switch_out_port
    import axis_switch_pkg::*;
#(
    parameter int N_IN       = DEF_N_IN,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int USER_WIDTH = DEF_USER_WIDTH,
    parameter int ID_WIDTH   = $clog2(N_IN)
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic [N_IN-1:0]                s_axis_tvalid,
    input  logic [N_IN*DATA_WIDTH-1:0]     s_axis_tdata,
    input  logic [N_IN*DATA_WIDTH/8-1:0]   s_axis_tkeep,
    input  logic [N_IN-1:0]                s_axis_tlast,
    input  logic [N_IN*USER_WIDTH-1:0]     s_axis_tuser,
    output logic [N_IN-1:0]                s_axis_tready,
    output logic                           m_axis_tvalid,
    output logic [DATA_WIDTH-1:0]          m_axis_tdata,
    output logic [DATA_WIDTH/8-1:0]        m_axis_tkeep,
    output logic                           m_axis_tlast,
    output logic [USER_WIDTH-1:0]          m_axis_tuser,
    input  logic                           m_axis_tready,
    output logic [N_IN-1:0]                arb_req_o,
    output logic                           arb_en_o,
    input  logic [N_IN-1:0]                arb_gnt_i,
    input  logic [ID_WIDTH-1:0]            arb_gnt_id_i
);

    localparam int KW = DATA_WIDTH / 8;

    sw_state_t               r_state;
    sw_state_t               w_state_nxt;
    logic [ID_WIDTH-1:0]     r_lock_id;
    logic [N_IN-1:0]         w_tready;
    logic [N_IN-1:0]         w_arb_req;
    logic                    w_arb_en;
    logic                    w_in_valid;
    logic                    w_in_last;
    logic                    w_out_free;
    logic [DATA_WIDTH-1:0]   w_in_data;
    logic [KW-1:0]           w_in_keep;
    logic [USER_WIDTH-1:0]   w_in_user;

    assign w_in_data = s_axis_tdata[
        src_lsb(32'(r_lock_id), DATA_WIDTH) +: DATA_WIDTH];
    assign w_in_keep = s_axis_tkeep[
        src_lsb(32'(r_lock_id), KW) +: KW];
    assign w_in_user = s_axis_tuser[
        src_lsb(32'(r_lock_id), USER_WIDTH) +: USER_WIDTH];
    assign w_in_last = s_axis_tlast[r_lock_id];

    always_comb begin
        w_state_nxt = r_state;
        w_tready    = '0;
        w_arb_req   = '0;
        w_arb_en    = 1'b0;
        w_in_valid  = 1'b0;
        unique case (r_state)
            IDLE: begin
                w_arb_req = s_axis_tvalid;
                w_arb_en  = |s_axis_tvalid;
                if (w_arb_en) begin
                    w_state_nxt = XFER;
                end
            end
            XFER: begin
                // Pointer frozen: no requests until the packet ends.
                w_tready[r_lock_id] = w_out_free;
                w_in_valid = s_axis_tvalid[r_lock_id];
                if (w_in_valid && w_out_free && w_in_last) begin
                    w_state_nxt = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= IDLE;
            r_lock_id <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == IDLE && w_arb_en) begin
                r_lock_id <= arb_gnt_id_i;
            end
        end
    end

    // Arbiter strobes stay quiet while reset is held.
    assign arb_req_o     = reset_n ? w_arb_req : '0;
    assign arb_en_o      = reset_n && w_arb_en;
    assign s_axis_tready = w_tready;

    axis_out_reg #(
        .DATA_WIDTH (DATA_WIDTH),
        .USER_WIDTH (USER_WIDTH)
    ) u_out_reg (
        .clk           (clk),
        .reset_n       (reset_n),
        .i_valid       (w_in_valid),
        .i_data        (w_in_data),
        .i_keep        (w_in_keep),
        .i_last        (w_in_last),
        .i_user        (w_in_user),
        .o_ready       (w_out_free),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tuser  (m_axis_tuser),
        .m_axis_tready (m_axis_tready)
    );

`ifndef SYNTHESIS
    a_rdy_onehot: assert property (@(posedge clk) disable iff (!reset_n)
        $onehot0(s_axis_tready));
    a_stall_stable: assert property (@(posedge clk) disable iff (!reset_n)
        (m_axis_tvalid && !m_axis_tready) |=>
        (m_axis_tvalid && $stable(m_axis_tdata) && $stable(m_axis_tkeep)
         && $stable(m_axis_tlast) && $stable(m_axis_tuser)));
    a_en_idle: assert property (@(posedge clk) disable iff (!reset_n)
        arb_en_o |-> (r_state == IDLE && |arb_req_o));
    a_lock_only: assert property (@(posedge clk) disable iff (!reset_n)
        (r_state == XFER) |->
        ((s_axis_tready & ~(N_IN'(1) << r_lock_id)) == '0));
    a_gnt_legal: assert property (@(posedge clk) disable iff (!reset_n)
        (|arb_req_o) |-> (|arb_gnt_i));
`endif

endmodule
